// File: rtl/aes_key_expand_ctrl.sv
// Runs one AES-128 key-schedule instance round by round and keeps all 11 round keys in a local table.
// Optional AES_KEY_CACHE_EN: a start carrying the key already expanded in the table skips the expansion.
module aes_key_expand_ctrl #(
  parameter int KS_LATENCY = 1,
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         tbl_valid,
  output logic         ks_en,
  output logic [127:0] ks_din,
  output logic [3:0]   ks_round,
  input  logic [127:0] ks_dout,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data
);

  localparam int         DEPTH      = NUM_ROUNDS + 1;
  localparam logic [2:0] CNT_LAST   = 3'(KS_LATENCY - 1);
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

  state_t         state_q, state_d;
  logic [3:0]     r_q, r_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [127:0]   ks_din_q, ks_din_d;
  logic [3:0]     ks_round_q, ks_round_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           tbl_valid_q, tbl_valid_d;
  logic [127:0]   rk_data_q, rk_data_d;
  logic [127:0]   tbl_q [DEPTH];
  logic [127:0]   tbl_d [DEPTH];

  logic           wr_en;
  logic [3:0]     wr_idx;
  logic [127:0]   wr_data;
  logic           cache_hit;

`ifdef AES_KEY_CACHE_EN
  assign cache_hit = tbl_valid_q && (key_in == tbl_q[0]);
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    ks_din_d    = ks_din_q;
    ks_round_d  = ks_round_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tbl_valid_d = tbl_valid_q;
    ks_en       = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = 4'd0;
    wr_data     = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cache_hit) begin
            // Table already holds this key's expansion: report completion only.
            state_d = FIN;
          end else begin
            wr_en       = 1'b1;
            wr_idx      = 4'd0;
            wr_data     = key_in;
            ks_din_d    = key_in;
            ks_round_d  = 4'd1;
            r_d         = 4'd1;
            tbl_valid_d = 1'b0;
            busy_d      = 1'b1;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        ks_en   = 1'b1;
        cnt_d   = 3'd0;
        state_d = WAIT;
      end
      WAIT: begin
        ks_en = 1'b1;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == CNT_LAST) begin
          wr_en   = 1'b1;
          wr_idx  = r_q;
          wr_data = ks_dout;
          if (r_q == LAST_ROUND) begin
            busy_d  = 1'b0;
            state_d = FIN;
          end else begin
            ks_din_d   = ks_dout;
            ks_round_d = r_q + 4'd1;
            r_d        = r_q + 4'd1;
            state_d    = ISSUE;
          end
        end
      end
      FIN: begin
        busy_d      = 1'b0;
        tbl_valid_d = 1'b1;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Single write port; reads below see the pre-write contents.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      tbl_d[i] = tbl_q[i];
      if (wr_en && (wr_idx == 4'(i))) tbl_d[i] = wr_data;
    end
  end

  always_comb begin
    rk_data_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rk_addr == 4'(i)) rk_data_d = tbl_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= 4'd0;
      cnt_q       <= 3'd0;
      ks_din_q    <= '0;
      ks_round_q  <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tbl_valid_q <= 1'b0;
      rk_data_q   <= '0;
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      ks_din_q    <= ks_din_d;
      ks_round_q  <= ks_round_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tbl_valid_q <= tbl_valid_d;
      rk_data_q   <= rk_data_d;
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= tbl_d[i];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign tbl_valid = tbl_valid_q;
  assign ks_din    = ks_din_q;
  assign ks_round  = ks_round_q;
  assign rk_data   = rk_data_q;

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Directed bench: two controllers, each paired with a behavioural AES-128 key schedule
// (latency 1 and latency 3), checked against hand-computed and model-computed round keys.
module tb_aes_key_expand_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_a, busy_a, done_a, tv_a, en_a;
  logic [127:0] key_a, din_a, rk_a;
  logic [127:0] dout_a = '0;
  logic [3:0]   rnd_a, addr_a;

  logic         start_b, busy_b, done_b, tv_b, en_b;
  logic [127:0] key_b, din_b, rk_b, dout_b;
  logic [3:0]   rnd_b, addr_b;
  logic [127:0] b_s0 = '0, b_s1 = '0, b_s2 = '0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] exp_tbl [0:10];

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

  aes_key_expand_ctrl #(.KS_LATENCY(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .key_in(key_a), .busy(busy_a), .done(done_a),
    .tbl_valid(tv_a), .ks_en(en_a), .ks_din(din_a), .ks_round(rnd_a), .ks_dout(dout_a),
    .rk_addr(addr_a), .rk_data(rk_a)
  );

  aes_key_expand_ctrl #(.KS_LATENCY(3)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .key_in(key_b), .busy(busy_b), .done(done_b),
    .tbl_valid(tv_b), .ks_en(en_b), .ks_din(din_b), .ks_round(rnd_b), .ks_dout(dout_b),
    .rk_addr(addr_b), .rk_data(rk_b)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    logic hi;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1b;
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] w;
    w = {v, v} << n;
    return w[15:8];
  endfunction

  // S-box from first principles: GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ks_round_fn(input logic [127:0] din, input logic [3:0] rnd);
    logic [31:0] w3, rot, t, n0, n1, n2, n3;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 1; i < int'(rnd); i++) rc = gmul(rc, 8'h02);
    w3  = din[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    t   = t ^ {rc, 24'h0};
    n0  = din[127:96] ^ t;
    n1  = din[95:64] ^ n0;
    n2  = din[63:32] ^ n1;
    n3  = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  always @(posedge clk) if (en_a) dout_a <= ks_round_fn(din_a, rnd_a);

  always @(posedge clk) begin
    if (en_b) b_s0 <= ks_round_fn(din_b, rnd_b);
    b_s1 <= b_s0;
    b_s2 <= b_s1;
  end
  assign dout_b = b_s2;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input logic [127:0] key);
    exp_tbl[0] = key;
    for (int i = 1; i <= 10; i++) exp_tbl[i] = ks_round_fn(exp_tbl[i-1], 4'(i));
  endtask

  task automatic read_a(input logic [3:0] a, output logic [127:0] d);
    addr_a = a;
    @(negedge clk);
    d = rk_a;
  endtask

  task automatic read_b(input logic [3:0] a, output logic [127:0] d);
    addr_b = a;
    @(negedge clk);
    d = rk_b;
  endtask

  task automatic check_tbl_a(input string tag);
    logic [127:0] d;
    for (int i = 0; i <= 10; i++) begin
      read_a(4'(i), d);
      chk($sformatf("%s_rk%0d", tag, i), d, exp_tbl[i]);
    end
  endtask

  // Pulses start on DUT A and follows the run cycle by cycle; cyc 0 is the cycle after the start edge.
  task automatic expand_a(input logic [127:0] key, input int extra_at, input int exp_done,
                          input bit exp_hit, input string tag);
    int done_cyc, en_cnt, rnd_err, tv_err;
    done_cyc = -1; en_cnt = 0; rnd_err = 0; tv_err = 0;
    key_a = key; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == extra_at) begin
        start_a = 1'b1; key_a = ~key;
      end else begin
        start_a = 1'b0; key_a = key;
      end
      if (en_a) begin
        en_cnt++;
        if (rnd_a != 4'(cyc / 2 + 1)) rnd_err++;
      end
      if (done_a) begin
        done_cyc = cyc;
        break;
      end
      if (tv_a !== exp_hit) tv_err++;
    end
    start_a = 1'b0;
    chk({tag, "_done_cycle"}, 128'(done_cyc), 128'(exp_done));
    chk({tag, "_ks_en_cycles"}, 128'(en_cnt), exp_hit ? 128'd0 : 128'd20);
    chk({tag, "_ks_round_seq_errs"}, 128'(rnd_err), 128'd0);
    chk({tag, "_tbl_valid_before_done_errs"}, 128'(tv_err), 128'd0);
    chk({tag, "_tbl_valid_at_done"}, 128'(tv_a), 128'd1);
    chk({tag, "_busy_at_done"}, 128'(busy_a), 128'd0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 128'(done_a), 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [127:0] d;
    int done_cyc;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    key_a = '0; key_b = '0; addr_a = 4'd0; addr_b = 4'd0;
    repeat (3) @(negedge clk);

    chk("rst_busy", 128'(busy_a), 128'd0);
    chk("rst_done", 128'(done_a), 128'd0);
    chk("rst_tbl_valid", 128'(tv_a), 128'd0);
    chk("rst_ks_en", 128'(en_a), 128'd0);
    chk("rst_ks_din", din_a, 128'd0);
    chk("rst_ks_round", 128'(rnd_a), 128'd0);
    chk("rst_rk_data", rk_a, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic expansion of the FIPS-197 example key.
    build_exp(K1);
    expand_a(K1, -1, 21, 1'b0, "c1");
    check_tbl_a("c1");
    read_a(4'd1, d);  chk("c1_const_rk1", d, 128'ha0fafe1788542cb123a339392a6c7605);
    read_a(4'd2, d);  chk("c1_const_rk2", d, 128'hf2c295f27a96b9435935807a7359f67f);
    read_a(4'd10, d); chk("c1_const_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_a(4'd0, d);  chk("c1_const_rk0", d, K1);
    chk("c1_ks_round_idle_hold", 128'(rnd_a), 128'd10);

    // Out-of-range read addresses.
    for (int a = 11; a <= 15; a++) begin
      read_a(4'(a), d);
      chk($sformatf("c4_oob_addr%0d", a), d, 128'd0);
    end

    // Start while busy (different key) must be ignored.
    expand_a(K1, 4, 21, 1'b0, "c2");
    check_tbl_a("c2");

`ifdef AES_KEY_CACHE_EN
    expand_a(K1, -1, 1, 1'b1, "c5_hit");
`else
    expand_a(K1, -1, 21, 1'b0, "c5_rerun");
`endif
    check_tbl_a("c5_same");

    build_exp(K2);
    expand_a(K2, -1, 21, 1'b0, "c5_newkey");
    check_tbl_a("c5_newkey");

    // Reset eight cycles into an expansion aborts everything.
    build_exp(K1);
    key_a = K1; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("c3_busy", 128'(busy_a), 128'd0);
    chk("c3_tbl_valid", 128'(tv_a), 128'd0);
    chk("c3_ks_en", 128'(en_a), 128'd0);
    chk("c3_rk_data", rk_a, 128'd0);
    rst = 1'b0;
    for (int a = 0; a <= 10; a++) begin
      read_a(4'(a), d);
      chk($sformatf("c3_cleared_rk%0d", a), d, 128'd0);
    end
    expand_a(K1, -1, 21, 1'b0, "c3_fresh");
    check_tbl_a("c3_fresh");

    // Latency-3 schedule on the second controller.
    done_cyc = -1;
    key_b = K1; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (done_b) begin
        done_cyc = cyc;
        break;
      end
    end
    chk("c6_done_cycle", 128'(done_cyc), 128'd41);
    chk("c6_tbl_valid", 128'(tv_b), 128'd1);
    for (int a = 0; a <= 10; a++) begin
      read_b(4'(a), d);
      chk($sformatf("c6_rk%0d", a), d, exp_tbl[a]);
    end
    read_b(4'd10, d);
    chk("c6_const_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
